// File: rtl/mem_ctrl_if.sv
// Pipeline/RAM bus bundle for mem_ctrl.
// slave = controller side, master = pipeline/RAM side.
interface mem_ctrl_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 32
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic [DATA_W-1:0] if_data_o;
    logic              if_done_o;
    logic              mem_req_i;
    logic              mem_wr_i;
    logic [1:0]        mem_size_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [DATA_W-1:0] mem_wdata_i;
    logic [DATA_W-1:0] mem_data_o;
    logic              mem_done_o;
    logic [7:0]        ram_data_i;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [7:0]        ram_data_o;
    logic              ram_wr_o;
    logic              busy_o;

    modport slave (
        input  if_req_i, if_addr_i,
        input  mem_req_i, mem_wr_i, mem_size_i,
        input  mem_addr_i, mem_wdata_i,
        input  ram_data_i,
        output if_data_o, if_done_o,
        output mem_data_o, mem_done_o,
        output ram_addr_o, ram_data_o, ram_wr_o,
        output busy_o
    );

    modport master (
        output if_req_i, if_addr_i,
        output mem_req_i, mem_wr_i, mem_size_i,
        output mem_addr_i, mem_wdata_i,
        output ram_data_i,
        input  if_data_o, if_done_o,
        input  mem_data_o, mem_done_o,
        input  ram_addr_o, ram_data_o, ram_wr_o,
        input  busy_o
    );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial IF/MEM arbiter onto an 8-bit RAM port.
// Define IF_BUF_EN for a one-entry fetch buffer.
module mem_ctrl #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 32
) (
    input logic     clk,
    input logic     rst,
    mem_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, IF_RD, MEM_RD, MEM_WR, DONE
    } state_t;

    state_t            state, state_nx;
    logic [2:0]        cnt, cnt_inc, n, mem_n;
    logic [ADDR_W-1:0] base;
    logic [DATA_W-1:0] wdata, asm_q, asm_nx;
    logic              acc_if, acc_mem, hit, last, rd_st;

`ifdef IF_BUF_EN
    logic              buf_vld;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_data;
    assign hit = buf_vld && (bus.if_addr_i == buf_addr);
`else
    assign hit = 1'b0;
`endif

    assign cnt_inc = cnt + 3'd1;
    assign rd_st   = (state == IF_RD) || (state == MEM_RD);

    always_comb begin
        mem_n = 3'd4;
        unique case (1'b1)
            (bus.mem_size_i == 2'b00): mem_n = 3'd1;
            (bus.mem_size_i == 2'b01): mem_n = 3'd2;
            default:                   mem_n = 3'd4;
        endcase
    end

    // byte k arrives one cycle after its address, i.e. while cnt = k+1
    always_comb begin
        asm_nx = asm_q;
        if (rd_st && cnt != 3'd0)
            asm_nx[{cnt[1:0] - 2'd1, 3'b000} +: 8] = bus.ram_data_i;
    end

    always_comb begin
        state_nx = state;
        acc_if   = 1'b0;
        acc_mem  = 1'b0;
        last     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.mem_req_i) begin
                    acc_mem  = 1'b1;
                    state_nx = bus.mem_wr_i ? MEM_WR : MEM_RD;
                end else if (bus.if_req_i) begin
                    acc_if   = 1'b1;
                    state_nx = hit ? DONE : IF_RD;
                end
            end
            IF_RD, MEM_RD: begin
                if (cnt == n) begin
                    last     = 1'b1;
                    state_nx = DONE;
                end
            end
            MEM_WR: begin
                if (cnt_inc == n) begin
                    last     = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt            <= '0;
            n              <= '0;
            base           <= '0;
            wdata          <= '0;
            asm_q          <= '0;
            bus.if_data_o  <= '0;
            bus.if_done_o  <= 1'b0;
            bus.mem_data_o <= '0;
            bus.mem_done_o <= 1'b0;
            bus.ram_addr_o <= '0;
            bus.ram_data_o <= '0;
            bus.ram_wr_o   <= 1'b0;
            bus.busy_o     <= 1'b0;
`ifdef IF_BUF_EN
            buf_vld        <= 1'b0;
            buf_addr       <= '0;
            buf_data       <= '0;
`endif
        end else begin
            bus.if_done_o  <= 1'b0;
            bus.mem_done_o <= 1'b0;
            bus.busy_o     <= (state_nx != IDLE);
            if (acc_mem) begin
                base           <= bus.mem_addr_i;
                wdata          <= bus.mem_wdata_i;
                n              <= mem_n;
                cnt            <= '0;
                asm_q          <= '0;
                bus.ram_addr_o <= bus.mem_addr_i;
                if (bus.mem_wr_i) begin
                    bus.ram_wr_o   <= 1'b1;
                    bus.ram_data_o <= bus.mem_wdata_i[7:0];
`ifdef IF_BUF_EN
                    buf_vld        <= 1'b0;
`endif
                end
            end else if (acc_if) begin
                base  <= bus.if_addr_i;
                n     <= 3'd4;
                cnt   <= '0;
                asm_q <= '0;
`ifdef IF_BUF_EN
                if (hit) begin
                    bus.if_done_o <= 1'b1;
                    bus.if_data_o <= buf_data;
                end else
`endif
                bus.ram_addr_o <= bus.if_addr_i;
            end else if (rd_st) begin
                asm_q <= asm_nx;
                if (last) begin
                    if (state == IF_RD) begin
                        bus.if_data_o <= asm_nx;
                        bus.if_done_o <= 1'b1;
`ifdef IF_BUF_EN
                        buf_vld       <= 1'b1;
                        buf_addr      <= base;
                        buf_data      <= asm_nx;
`endif
                    end else begin
                        bus.mem_data_o <= asm_nx;
                        bus.mem_done_o <= 1'b1;
                    end
                end else begin
                    cnt <= cnt_inc;
                    if (cnt_inc < n)
                        bus.ram_addr_o <= base + ADDR_W'(cnt_inc);
                end
            end else if (state == MEM_WR) begin
                if (last) begin
                    bus.ram_wr_o   <= 1'b0;
                    bus.ram_data_o <= '0;
                    bus.mem_done_o <= 1'b1;
                end else begin
                    cnt            <= cnt_inc;
                    bus.ram_addr_o <= base + ADDR_W'(cnt_inc);
                    bus.ram_data_o <= wdata[{cnt_inc[1:0], 3'b000} +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a
// behavioural 8-bit RAM (one-cycle read latency).
module tb_mem_ctrl;
    logic clk;
    logic rst;
    int   nchk = 0;
    int   nerr = 0;
    int   lat;
    int   j;

    logic [7:0]  ram [0:131071];
    logic [16:0] cyc_addr [0:21];
    logic        cyc_wr   [0:21];
    logic [7:0]  cyc_dat  [0:21];

    mem_ctrl_if #(.ADDR_W(17), .DATA_W(32)) bus ();

    mem_ctrl #(.ADDR_W(17), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        bus.ram_data_i <= ram[bus.ram_addr_o];
        if (bus.ram_wr_o) ram[bus.ram_addr_o] <= bus.ram_data_o;
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one request from a negedge; lat = edges from accept to done.
    task automatic run(input logic m, input logic wr,
                       input logic [1:0] sz, input logic [16:0] a,
                       input logic [31:0] wd, output int l);
        if (m) begin
            bus.mem_req_i   = 1'b1;
            bus.mem_wr_i    = wr;
            bus.mem_size_i  = sz;
            bus.mem_addr_i  = a;
            bus.mem_wdata_i = wd;
        end else begin
            bus.if_req_i  = 1'b1;
            bus.if_addr_i = a;
        end
        l = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            cyc_addr[k] = bus.ram_addr_o;
            cyc_wr[k]   = bus.ram_wr_o;
            cyc_dat[k]  = bus.ram_data_o;
            if ((m && bus.mem_done_o) || (!m && bus.if_done_o)) begin
                l = k - 1;
                break;
            end
        end
        bus.mem_req_i = 1'b0;
        bus.if_req_i  = 1'b0;
        if (l < 0) chk("timeout", 32'd0, 32'd1);
    endtask

    task automatic tail();
        @(negedge clk);
        chk("if_done_pulse", {31'd0, bus.if_done_o}, 32'd0);
        chk("mem_done_pulse", {31'd0, bus.mem_done_o}, 32'd0);
    endtask

    initial begin
        rst             = 1'b0;
        bus.if_req_i    = 1'b0;
        bus.if_addr_i   = '0;
        bus.mem_req_i   = 1'b0;
        bus.mem_wr_i    = 1'b0;
        bus.mem_size_i  = 2'b00;
        bus.mem_addr_i  = '0;
        bus.mem_wdata_i = '0;
        bus.ram_data_i  = '0;
        ram[17'h00100] = 8'h13; ram[17'h00101] = 8'h05;
        ram[17'h00102] = 8'h00; ram[17'h00103] = 8'h00;
        ram[17'h1FFFE] = 8'hAA; ram[17'h1FFFF] = 8'hBB;
        ram[17'h00000] = 8'hCC; ram[17'h00001] = 8'hDD;
        ram[17'h00300] = 8'h11; ram[17'h00301] = 8'h22;
        ram[17'h00200] = 8'h93; ram[17'h00201] = 8'h00;
        ram[17'h00202] = 8'h10; ram[17'h00203] = 8'h00;
        ram[17'h00010] = 8'h00; ram[17'h00011] = 8'h00;

        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("rst_ram_wr", {31'd0, bus.ram_wr_o}, 32'd0);
        chk("rst_ram_addr", {15'd0, bus.ram_addr_o}, 32'd0);
        chk("rst_if_data", bus.if_data_o, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // IF word fetch
        run(1'b0, 1'b0, 2'b00, 17'h00100, 32'd0, lat);
        chk("ifrd_lat", lat, 32'd5);
        chk("ifrd_a1", {15'd0, cyc_addr[1]}, 32'h00100);
        chk("ifrd_a2", {15'd0, cyc_addr[2]}, 32'h00101);
        chk("ifrd_a3", {15'd0, cyc_addr[3]}, 32'h00102);
        chk("ifrd_a4", {15'd0, cyc_addr[4]}, 32'h00103);
        chk("ifrd_wr1", {31'd0, cyc_wr[1]}, 32'd0);
        chk("ifrd_wdat1", {24'd0, cyc_dat[1]}, 32'd0);
        chk("ifrd_data", bus.if_data_o, 32'h00000513);
        tail();

        // byte store
        run(1'b1, 1'b1, 2'b00, 17'h00010, 32'hDEADBEEF, lat);
        chk("sb_lat", lat, 32'd1);
        chk("sb_wr1", {31'd0, cyc_wr[1]}, 32'd1);
        chk("sb_a1", {15'd0, cyc_addr[1]}, 32'h00010);
        chk("sb_d1", {24'd0, cyc_dat[1]}, 32'h000000EF);
        chk("sb_wr_off", {31'd0, bus.ram_wr_o}, 32'd0);
        chk("sb_ram10", {24'd0, ram[17'h00010]}, 32'h000000EF);
        chk("sb_ram11", {24'd0, ram[17'h00011]}, 32'h00000000);
        tail();

        // half store
        run(1'b1, 1'b1, 2'b01, 17'h00010, 32'hDEADBEEF, lat);
        chk("sh_lat", lat, 32'd2);
        chk("sh_d1", {24'd0, cyc_dat[1]}, 32'h000000EF);
        chk("sh_a2", {15'd0, cyc_addr[2]}, 32'h00011);
        chk("sh_d2", {24'd0, cyc_dat[2]}, 32'h000000BE);
        chk("sh_wr2", {31'd0, cyc_wr[2]}, 32'd1);
        chk("sh_ram11", {24'd0, ram[17'h00011]}, 32'h000000BE);
        tail();

        // word load wrapping past the top of the address space
        run(1'b1, 1'b0, 2'b11, 17'h1FFFE, 32'hFFFFFFFF, lat);
        chk("wrap_lat", lat, 32'd5);
        chk("wrap_a1", {15'd0, cyc_addr[1]}, 32'h1FFFE);
        chk("wrap_a2", {15'd0, cyc_addr[2]}, 32'h1FFFF);
        chk("wrap_a3", {15'd0, cyc_addr[3]}, 32'h00000);
        chk("wrap_a4", {15'd0, cyc_addr[4]}, 32'h00001);
        chk("wrap_data", bus.mem_data_o, 32'hDDCCBBAA);
        tail();

        // byte load
        run(1'b1, 1'b0, 2'b00, 17'h00100, 32'd0, lat);
        chk("lb_lat", lat, 32'd2);
        chk("lb_data", bus.mem_data_o, 32'h00000013);
        tail();

        // simultaneous IF and MEM: MEM first
        bus.if_req_i    = 1'b1;
        bus.if_addr_i   = 17'h00100;
        bus.mem_req_i   = 1'b1;
        bus.mem_wr_i    = 1'b0;
        bus.mem_size_i  = 2'b01;
        bus.mem_addr_i  = 17'h00300;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.if_done_o) chk("arb_if_early", 32'd1, 32'd0);
            if (bus.mem_done_o) begin
                lat = k - 1;
                break;
            end
        end
        bus.mem_req_i = 1'b0;
        chk("arb_mem_lat", lat, 32'd3);
        chk("arb_mem_data", bus.mem_data_o, 32'h00002211);
        j = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.if_done_o) begin
                j = k;
                break;
            end
        end
        chk("arb_if_gap", j, 32'd7);
        chk("arb_if_data", bus.if_data_o, 32'h00000513);
        chk("arb_mem_hold", bus.mem_data_o, 32'h00002211);
        // request still high through DONE must not be taken again
        @(negedge clk);
        chk("arb_no_reacc", {31'd0, bus.busy_o}, 32'd0);
        bus.if_req_i = 1'b0;
        @(negedge clk);
        chk("arb_idle", {31'd0, bus.busy_o}, 32'd0);

        // reset in the middle of a word fetch
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 17'h00100;
        repeat (3) @(negedge clk);
        chk("mid_busy", {31'd0, bus.busy_o}, 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("ar_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("ar_addr", {15'd0, bus.ram_addr_o}, 32'd0);
        chk("ar_if_data", bus.if_data_o, 32'd0);
        chk("ar_mem_data", bus.mem_data_o, 32'd0);
        bus.if_req_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        j = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.if_done_o || bus.mem_done_o || bus.busy_o) j++;
        end
        chk("ar_quiet", j, 32'd0);

`ifdef IF_BUF_EN
        run(1'b0, 1'b0, 2'b00, 17'h00200, 32'd0, lat);
        chk("buf_miss_lat", lat, 32'd5);
        chk("buf_miss_data", bus.if_data_o, 32'h00100093);
        tail();
        run(1'b0, 1'b0, 2'b00, 17'h00200, 32'd0, lat);
        chk("buf_hit_lat", lat, 32'd0);
        chk("buf_hit_data", bus.if_data_o, 32'h00100093);
        chk("buf_hit_noram", {15'd0, bus.ram_addr_o}, 32'h00203);
        tail();
        run(1'b1, 1'b1, 2'b00, 17'h00020, 32'h00000055, lat);
        tail();
        run(1'b0, 1'b0, 2'b00, 17'h00200, 32'd0, lat);
        chk("buf_inval_lat", lat, 32'd5);
        chk("buf_inval_a1", {15'd0, cyc_addr[1]}, 32'h00200);
        tail();
`else
        run(1'b0, 1'b0, 2'b00, 17'h00200, 32'd0, lat);
        chk("refetch1_lat", lat, 32'd5);
        tail();
        run(1'b0, 1'b0, 2'b00, 17'h00200, 32'd0, lat);
        chk("refetch2_lat", lat, 32'd5);
        chk("refetch2_data", bus.if_data_o, 32'h00100093);
        tail();
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
